// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared types and constants for the frame packer: FSM state encoding, the
// default SYNC byte, header field layout and checksum width, plus a helper
// that assembles the header byte from its fields.
// -----------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Header byte layout: {overflow, seq[6:0]}
  localparam int OVF_BIT = 7;
  localparam int SEQ_W   = 7;

  localparam int CSUM_W  = 8;

  function automatic logic [7:0] make_header(input logic ovf,
                                             input logic [SEQ_W-1:0] seq);
    logic [7:0] hdr;
    hdr             = '0;
    hdr[OVF_BIT]    = ovf;
    hdr[SEQ_W-1:0]  = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/frame_packer_if.sv
// -----------------------------------------------------------------------------
// frame_packer_if
// Bundles the two streams around the frame packer:
//   in_*  : sample stream from the skid buffer (valid/ready, data, sticky ovf)
//   out_* : byte stream towards the UART/byte link (valid/ready, data, last)
// Modports:
//   master : the packer itself (consumes samples, produces bytes)
//   slave  : the surrounding environment (produces samples, consumes bytes)
// -----------------------------------------------------------------------------
interface frame_packer_if #(
  parameter int DATA_SIZE = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_overflow;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_last;

  modport master (
    input  in_valid, in_data, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/frame_packer.sv
// -----------------------------------------------------------------------------
// frame_packer
// Packs SAMPLES_PER_FRAME samples of DATA_SIZE bits into a byte-wide frame:
//   SYNC, {overflow, seq[6:0]}, payload bytes MSB-first, 8-bit additive checksum
// The checksum covers header and payload bytes. The overflow bit is sampled
// once per frame, when SYNC is loaded.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : frame_packer_if.master (sample input stream, byte output stream)
// -----------------------------------------------------------------------------
module frame_packer
  import frame_pkg::*;
#(
  parameter int         DATA_SIZE         = 16,
  parameter int         SAMPLES_PER_FRAME = 4,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_packer_if.master bus
);

  localparam int BYTES  = DATA_SIZE / 8;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SAMP_W = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(SAMPLES_PER_FRAME - 1);

  if (DATA_SIZE < 8 || (DATA_SIZE % 8) != 0) begin : g_bad_data_size
    $error("frame_packer: DATA_SIZE must be a multiple of 8 and >= 8");
  end
  if (SAMPLES_PER_FRAME < 1) begin : g_bad_spf
    $error("frame_packer: SAMPLES_PER_FRAME must be >= 1");
  end

  state_e               state_q,      state_d;
  logic                 out_valid_q,  out_valid_d;
  logic [7:0]           out_data_q,   out_data_d;
  logic                 out_last_q,   out_last_d;
  logic [SEQ_W-1:0]     seq_q,        seq_d;
  logic [CSUM_W-1:0]    csum_q,       csum_d;
  logic [BYTE_W-1:0]    byte_idx_q,   byte_idx_d;
  logic [SAMP_W-1:0]    samp_idx_q,   samp_idx_d;
  logic [DATA_SIZE-1:0] shift_q,      shift_d;
  logic                 hdr_ovf_q,    hdr_ovf_d;

  logic       slot_free;
  logic       in_ready;
  logic       load;
  logic [7:0] load_byte;
  logic       load_last;
  logic       sample_done;

  // The output register can take a new byte when empty or being drained now.
  assign slot_free = !out_valid_q || bus.out_ready;
  // Samples are only taken at a sample boundary; in_valid never feeds in_ready.
  assign in_ready  = (state_q == DATA) && (byte_idx_q == '0) && slot_free;

  always_comb begin
    // NOTE: every signal written here is defaulted first so no latch is inferred.
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    samp_idx_d  = samp_idx_q;
    shift_d     = shift_q;
    hdr_ovf_d   = hdr_ovf_q;
    load        = 1'b0;
    load_byte   = 8'h00;
    load_last   = 1'b0;
    sample_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && slot_free) begin
          load      = 1'b1;
          load_byte = SYNC_BYTE;
          hdr_ovf_d = bus.in_overflow;
          state_d   = HEADER;
        end
      end

      HEADER: begin
        if (slot_free) begin
          load       = 1'b1;
          load_byte  = make_header(hdr_ovf_q, seq_q);
          csum_d     = load_byte;
          byte_idx_d = '0;
          samp_idx_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        if (byte_idx_q == '0) begin
          if (bus.in_valid && in_ready) begin
            load      = 1'b1;
            load_byte = bus.in_data[DATA_SIZE-1 -: 8];
            shift_d   = bus.in_data << 8;
            csum_d    = csum_q + load_byte;
            if (LAST_BYTE == '0) sample_done = 1'b1;
            else                 byte_idx_d  = BYTE_W'(1);
          end
        end else if (slot_free) begin
          load      = 1'b1;
          load_byte = shift_q[DATA_SIZE-1 -: 8];
          shift_d   = shift_q << 8;
          csum_d    = csum_q + load_byte;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d  = '0;
            sample_done = 1'b1;
          end else begin
            byte_idx_d  = byte_idx_q + BYTE_W'(1);
          end
        end

        if (sample_done) begin
          if (samp_idx_q == LAST_SAMP) begin
            samp_idx_d = '0;
            state_d    = CSUM;
          end else begin
            samp_idx_d = samp_idx_q + SAMP_W'(1);
          end
        end
      end

      CSUM: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = csum_q;
          load_last = 1'b1;
          seq_d     = seq_q + SEQ_W'(1);
          csum_d    = '0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Output register: load a new byte, or drop valid once the current one is taken.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_byte;
      out_last_d  = load_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: the shift register is reset along with the control state; it is small
  // and a clean reset value keeps the discarded partial sample out of view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      seq_q       <= '0;
      csum_q      <= '0;
      byte_idx_q  <= '0;
      samp_idx_q  <= '0;
      shift_q     <= '0;
      hdr_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
      samp_idx_q  <= samp_idx_d;
      shift_q     <= shift_d;
      hdr_ovf_q   <= hdr_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_packer
// Self-checking bench for frame_packer with DATA_SIZE=16, SAMPLES_PER_FRAME=2.
// A per-cycle vector table covers plain frames, the overflow header bit,
// an output stall and an input gap; hand-written sequences cover reset in the
// middle of a frame and 129 back-to-back frames with sequence wrap.
// -----------------------------------------------------------------------------
module tb_frame_packer;

  localparam int DS  = 16;
  localparam int SPF = 2;

  logic clk;
  logic rst_n;

  frame_packer_if #(.DATA_SIZE(DS)) bus ();

  frame_packer #(
    .DATA_SIZE         (DS),
    .SAMPLES_PER_FRAME (SPF),
    .SYNC_BYTE         (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One record per clock: inputs applied at a falling edge, in_ready checked
  // right after, outputs checked at the next falling edge.
  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ovf;
    logic        ordy;
    logic        exp_ir;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic        exp_l;
  } vec_t;

  localparam int NVEC = 39;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic ovf,
                              input logic ordy, input logic ir, input logic v,
                              input logic [7:0] ed, input logic l);
    vec_t r;
    r.iv = iv; r.d = d; r.ovf = ovf; r.ordy = ordy;
    r.exp_ir = ir; r.exp_v = v; r.exp_d = ed; r.exp_l = l;
    return r;
  endfunction

  // Back-to-back stream: 2 samples per frame, bytes checked against a model.
  task automatic run_stream(input int nframes);
    logic [15:0] samp [$];
    logic [7:0]  exp_b [$];
    logic        exp_l [$];
    logic [7:0]  cs;
    logic [7:0]  hdr;
    int k, si, total, cyc;
    for (int f = 0; f < nframes; f++) begin
      hdr = {1'b0, 7'(f)};
      cs  = hdr;
      exp_b.push_back(8'hA5); exp_l.push_back(1'b0);
      exp_b.push_back(hdr);   exp_l.push_back(1'b0);
      for (int s = 0; s < SPF; s++) begin
        logic [15:0] sv;
        sv = 16'((f * SPF + s) * 16'h0101 + 16'h003C);
        samp.push_back(sv);
        exp_b.push_back(sv[15:8]); exp_l.push_back(1'b0);
        exp_b.push_back(sv[7:0]);  exp_l.push_back(1'b0);
        cs = cs + sv[15:8] + sv[7:0];
      end
      exp_b.push_back(cs); exp_l.push_back(1'b1);
    end
    total = exp_b.size();
    k = 0; si = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (k < total && cyc < total + 50) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        check($sformatf("stream_byte[%0d]", k), {24'h0, bus.out_data}, {24'h0, exp_b[k]});
        check($sformatf("stream_last[%0d]", k), {31'h0, bus.out_last}, {31'h0, exp_l[k]});
        k++;
      end else if (k > 0) begin
        check($sformatf("stream_no_idle[%0d]", k), {31'h0, bus.out_valid}, 32'h1);
      end
      bus.in_valid = (si < samp.size());
      bus.in_data  = (si < samp.size()) ? samp[si] : 16'h0000;
      #1;
      if (bus.in_valid && bus.in_ready) si++;
    end
    check("stream_complete", k, total);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_no_extra", {31'h0, bus.out_valid}, 32'h0);
  endtask

  initial begin
    int  wait_cyc;
    // Frame 1 (seq 0): A5 00 12 34 AB CD BE
    vecs[0]  = mk(1, 16'h1234, 0, 1, 0, 1, 8'hA5, 0);
    vecs[1]  = mk(1, 16'h1234, 0, 1, 0, 1, 8'h00, 0);
    vecs[2]  = mk(1, 16'h1234, 0, 1, 1, 1, 8'h12, 0);
    vecs[3]  = mk(1, 16'hABCD, 0, 1, 0, 1, 8'h34, 0);
    vecs[4]  = mk(1, 16'hABCD, 0, 1, 1, 1, 8'hAB, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 0, 1, 8'hCD, 0);
    vecs[6]  = mk(0, 16'h0000, 0, 1, 0, 1, 8'hBE, 1);
    vecs[7]  = mk(0, 16'h0000, 0, 1, 0, 0, 8'h00, 0);
    // Frame 2 (seq 1), overflow seen only at SYNC: A5 81 00 00 00 01 82
    vecs[8]  = mk(1, 16'h0000, 1, 1, 0, 1, 8'hA5, 0);
    vecs[9]  = mk(1, 16'h0000, 0, 1, 0, 1, 8'h81, 0);
    vecs[10] = mk(1, 16'h0000, 0, 1, 1, 1, 8'h00, 0);
    vecs[11] = mk(1, 16'h0001, 0, 1, 0, 1, 8'h00, 0);
    vecs[12] = mk(1, 16'h0001, 0, 1, 1, 1, 8'h00, 0);
    vecs[13] = mk(0, 16'h0000, 0, 1, 0, 1, 8'h01, 0);
    vecs[14] = mk(0, 16'h0000, 0, 1, 0, 1, 8'h82, 1);
    vecs[15] = mk(0, 16'h0000, 0, 1, 0, 0, 8'h00, 0);
    // Frame 3 (seq 2), sink stalls 3 cycles on 0x34: A5 02 12 34 AB CD C0
    vecs[16] = mk(1, 16'h1234, 0, 1, 0, 1, 8'hA5, 0);
    vecs[17] = mk(1, 16'h1234, 0, 1, 0, 1, 8'h02, 0);
    vecs[18] = mk(1, 16'h1234, 0, 1, 1, 1, 8'h12, 0);
    vecs[19] = mk(1, 16'hABCD, 0, 1, 0, 1, 8'h34, 0);
    vecs[20] = mk(1, 16'hABCD, 0, 0, 0, 1, 8'h34, 0);
    vecs[21] = mk(1, 16'hABCD, 0, 0, 0, 1, 8'h34, 0);
    vecs[22] = mk(1, 16'hABCD, 0, 0, 0, 1, 8'h34, 0);
    vecs[23] = mk(1, 16'hABCD, 0, 1, 1, 1, 8'hAB, 0);
    vecs[24] = mk(0, 16'h0000, 0, 1, 0, 1, 8'hCD, 0);
    vecs[25] = mk(0, 16'h0000, 0, 1, 0, 1, 8'hC0, 1);
    vecs[26] = mk(0, 16'h0000, 0, 1, 0, 0, 8'h00, 0);
    // Frame 4 (seq 3), source idle 5 cycles between samples: A5 03 12 34 AB CD C1
    vecs[27] = mk(1, 16'h1234, 0, 1, 0, 1, 8'hA5, 0);
    vecs[28] = mk(1, 16'h1234, 0, 1, 0, 1, 8'h03, 0);
    vecs[29] = mk(1, 16'h1234, 0, 1, 1, 1, 8'h12, 0);
    vecs[30] = mk(0, 16'h0000, 0, 1, 0, 1, 8'h34, 0);
    vecs[31] = mk(0, 16'h0000, 0, 1, 1, 0, 8'h00, 0);
    vecs[32] = mk(0, 16'h0000, 0, 1, 1, 0, 8'h00, 0);
    vecs[33] = mk(0, 16'h0000, 0, 1, 1, 0, 8'h00, 0);
    vecs[34] = mk(0, 16'h0000, 0, 1, 1, 0, 8'h00, 0);
    vecs[35] = mk(1, 16'hABCD, 0, 1, 1, 1, 8'hAB, 0);
    vecs[36] = mk(0, 16'h0000, 0, 1, 0, 1, 8'hCD, 0);
    vecs[37] = mk(0, 16'h0000, 0, 1, 0, 1, 8'hC1, 1);
    vecs[38] = mk(0, 16'h0000, 0, 1, 0, 0, 8'h00, 0);

    // Reset
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 16'h0000;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("reset_out_data",  {24'h0, bus.out_data},  32'h0);
    check("reset_out_last",  {31'h0, bus.out_last},  32'h0);
    check("reset_in_ready",  {31'h0, bus.in_ready},  32'h0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid    = vecs[i].iv;
      bus.in_data     = vecs[i].d;
      bus.in_overflow = vecs[i].ovf;
      bus.out_ready   = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'h0, bus.in_ready}, {31'h0, vecs[i].exp_ir});
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].exp_v});
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_out_data", i), {24'h0, bus.out_data}, {24'h0, vecs[i].exp_d});
        check($sformatf("vec%0d_out_last", i), {31'h0, bus.out_last}, {31'h0, vecs[i].exp_l});
      end
    end

    // Reset in the middle of DATA, right after 0x12 is presented
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.out_ready = 1'b1;
    wait_cyc = 0;
    while (!(bus.out_valid && bus.out_data == 8'h12) && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midreset_saw_12", {24'h0, bus.out_data}, 32'h12);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("midreset_out_data",  {24'h0, bus.out_data},  32'h0);
    check("midreset_in_ready",  {31'h0, bus.in_ready},  32'h0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // 129 back-to-back frames after reset: seq 0..127 then 0
    run_stream(129);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
